// File: rtl/nec_key_events_pkg.sv
// Shared definitions for the NEC key-event block: frame field positions,
// state and event encodings, and the event payload layout.
package nec_key_events_pkg;

    localparam int unsigned FRAME_W    = 32;
    localparam int unsigned CODE_W     = 24;
    localparam int unsigned EV_W       = 26;
    localparam int unsigned TIMER_W    = 32;
    localparam int unsigned ERR_W      = 8;

    // Byte positions within the receiver word
    localparam int unsigned ADDR_POS   = 24;
    localparam int unsigned ADDR_N_POS = 16;
    localparam int unsigned CMD_POS    = 8;
    localparam int unsigned CMD_N_POS  = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_SWAP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EV_NONE    = 2'b00,
        EV_PRESS   = 2'b01,
        EV_REPEAT  = 2'b10,
        EV_RELEASE = 2'b11
    } ev_type_e;

    typedef struct packed {
        ev_type_e    ev_type;
        logic [15:0] addr;
        logic [7:0]  cmd;
    } event_t;

    function automatic event_t make_event(input ev_type_e t, input logic [CODE_W-1:0] code);
        event_t e;
        e.ev_type = t;
        e.addr    = code[23:8];
        e.cmd     = code[7:0];
        return e;
    endfunction

endpackage

// File: rtl/nec_key_events_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign do_pop_c  = pop_i && !empty_o;
    assign do_push_c = push_i && (!full_o || do_pop_c);
    assign head_o    = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push_c) wr_d = wr_q + AW'(1);
        if (do_pop_c)  rd_d = rd_q + AW'(1);
        count_d = count_q + CW'(do_push_c) - CW'(do_pop_c);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the head is masked while empty
    always_ff @(posedge clk_i) begin
        if (do_push_c) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/nec_key_events.sv
// NEC frame validator and key-hold tracker producing PRESS/REPEAT/RELEASE
// events into an FWFT event FIFO.
module nec_key_events
    import nec_key_events_pkg::*;
#(
    parameter int unsigned F_CLK      = 100_000_000,
    parameter int unsigned RELEASE_MS = 120,
    parameter bit          EXT_ADDR   = 1'b0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] burst,
    input  logic               ready,
    output logic               ev_valid,
    output logic [EV_W-1:0]    ev_data,
    input  logic               ev_pop,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               overflow
);

    localparam int unsigned   RELEASE_CYCLES = F_CLK / 1000 * RELEASE_MS;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RELEASE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                ovf_q, ovf_d;

    logic                cmd_ok_c, addr_ok_c, frame_ok_c;
    logic [15:0]         addr16_c;
    logic [CODE_W-1:0]   frame_code_c;
    logic                push_c, err_inc_c;
    event_t              push_ev_c;
    logic [EV_W-1:0]     push_vec_c;
    logic                fifo_full, fifo_empty;

    // Frame check and code extraction
    assign cmd_ok_c     = ((burst[CMD_POS +: 8] ^ burst[CMD_N_POS +: 8]) == 8'hFF);
    assign addr_ok_c    = EXT_ADDR || ((burst[ADDR_POS +: 8] ^ burst[ADDR_N_POS +: 8]) == 8'hFF);
    assign frame_ok_c   = cmd_ok_c && addr_ok_c;
    assign addr16_c     = EXT_ADDR ? burst[ADDR_N_POS +: 16] : {8'h00, burst[ADDR_POS +: 8]};
    assign frame_code_c = {addr16_c, burst[CMD_POS +: 8]};

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        timer_d   = timer_q;
        push_c    = 1'b0;
        push_ev_c = '0;
        err_inc_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (ready) begin
                    if (frame_ok_c) begin
                        push_c    = 1'b1;
                        push_ev_c = make_event(EV_PRESS, frame_code_c);
                        code_d    = frame_code_c;
                        state_d   = S_HELD;
                    end else begin
                        err_inc_c = 1'b1;
                    end
                end
            end
            S_HELD: begin
                timer_d = timer_q + TIMER_W'(1);
                // A valid frame takes priority over a coincident timeout
                if (ready && frame_ok_c) begin
                    push_c = 1'b1;
                    if (frame_code_c == code_q) begin
                        push_ev_c = make_event(EV_REPEAT, code_q);
                        timer_d   = '0;
                    end else begin
                        push_ev_c = make_event(EV_RELEASE, code_q);
                        code_d    = frame_code_c;
                        state_d   = S_SWAP;
                    end
                end else begin
                    err_inc_c = ready;
                    if (timer_q == TIMER_LAST) begin
                        push_c    = 1'b1;
                        push_ev_c = make_event(EV_RELEASE, code_q);
                        timer_d   = '0;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_SWAP: begin
                push_c    = 1'b1;
                push_ev_c = make_event(EV_PRESS, code_q);
                timer_d   = '0;
                state_d   = S_HELD;
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        err_d = err_q;
        ovf_d = ovf_q;
        if (err_inc_c && (err_q != '1)) err_d = err_q + ERR_W'(1);
        if (push_c && fifo_full && !(ev_pop && !fifo_empty)) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            timer_q <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign push_vec_c = push_ev_c;

    sync_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push_c),
        .push_data_i (push_vec_c),
        .pop_i       (ev_pop),
        .head_o      (ev_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign err_cnt  = err_q;
    assign overflow = ovf_q;

endmodule
